// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU bus and PSRAM handshake signals of the bus responder
interface cpu_bus_responder_if;
   logic [15:0] addr;
   logic        we;
   logic [7:0]  cpu_do;
   logic [7:0]  cpu_di;
   logic        rdy;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   // The responder's view: answers the CPU and drives memCtrl.
   modport slave (
      input  addr, we, cpu_do, mem_ack, mem_rdata,
      output cpu_di, rdy, mem_req, mem_we, mem_addr, mem_wdata
   );

   // The environment's view: the CPU plus memCtrl.
   modport master (
      output addr, we, cpu_do, mem_ack, mem_rdata,
      input  cpu_di, rdy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - 6502 bus slave: vectors, boot ROM, VIC colours, PSRAM with stall and timeout
module cpu_bus_responder #(
   parameter logic [15:0]            RESET_VECTOR = 16'hE000,
   parameter logic [15:0]            NMI_VECTOR   = 16'hE000,
   parameter logic [15:0]            IRQ_VECTOR   = 16'hE000,
   parameter logic [15:0]            ROM_BASE     = 16'hE000,
   parameter int                     ROM_BYTES    = 256,
   parameter logic [8*ROM_BYTES-1:0] ROM_IMAGE    = '0,
   parameter int                     MEM_TIMEOUT  = 255
) (
   input  logic              clkPhi0,
   input  logic              reset,
   cpu_bus_responder_if.slave bus,
   output logic [3:0]        border_color,
   output logic [3:0]        bg_color,
   output logic              bus_error
);

   localparam int          ROM_AW       = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
   localparam logic [7:0]  TIMEOUT_LAST = 8'(MEM_TIMEOUT);
   localparam logic [15:0] VIC_BORDER   = 16'hD020;
   localparam logic [15:0] VIC_BG       = 16'hD021;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cpu_di_q, cpu_di_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  count_next;
   logic        bus_error_q, bus_error_d;
   logic [3:0]  border_q, border_d;
   logic [3:0]  bg_q, bg_d;

   logic              is_vec, is_rom, is_vic, is_ext;
   logic [16:0]       rom_off;
   logic [ROM_AW-1:0] rom_idx;
   logic [7:0]        int_data;

   // Addresses below ROM_BASE wrap to a large offset and fall outside the ROM window.
   assign rom_off = {1'b0, bus.addr} - {1'b0, ROM_BASE};
   assign rom_idx = rom_off[ROM_AW-1:0];
   assign is_vec  = (bus.addr >= 16'hFFFA);
   assign is_rom  = !is_vec && (rom_off < 17'(ROM_BYTES));
   assign is_vic  = !is_vec && !is_rom && (bus.addr[15:10] == 6'b110100);
   assign is_ext  = !(is_vec || is_rom || is_vic);

   always_comb begin
      int_data = 8'hFF;
      if (is_vec) begin
         case (bus.addr[2:0])
            3'b010:  int_data = NMI_VECTOR[7:0];
            3'b011:  int_data = NMI_VECTOR[15:8];
            3'b100:  int_data = RESET_VECTOR[7:0];
            3'b101:  int_data = RESET_VECTOR[15:8];
            3'b110:  int_data = IRQ_VECTOR[7:0];
            3'b111:  int_data = IRQ_VECTOR[15:8];
            default: int_data = 8'hFF;
         endcase
      end else if (is_rom) begin
         int_data = ROM_IMAGE[{rom_idx, 3'b000} +: 8];
      end else if (is_vic) begin
         if (bus.addr == VIC_BORDER)
            int_data = {4'hF, border_q};
         else if (bus.addr == VIC_BG)
            int_data = {4'hF, bg_q};
      end
   end

   assign count_next = count_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      cpu_di_d    = cpu_di_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      count_d     = count_q;
      bus_error_d = bus_error_q;
      border_d    = border_q;
      bg_d        = bg_q;

      case (state_q)
         WAIT: begin
            if (bus.mem_ack) begin
               if (!mem_we_q)
                  cpu_di_d = bus.mem_rdata;
               state_d = DONE;
            end else if (count_next == TIMEOUT_LAST) begin
               cpu_di_d    = 8'hFF;
               bus_error_d = 1'b1;
               state_d     = DONE;
            end else begin
               count_d = count_next;
            end
         end
         default: begin
            // DONE still serves internal addresses but never starts a new PSRAM access.
            if (state_q == IDLE && is_ext) begin
               mem_req_d   = 1'b1;
               mem_we_d    = bus.we;
               mem_addr_d  = bus.addr;
               mem_wdata_d = bus.cpu_do;
               count_d     = 8'd0;
               state_d     = WAIT;
            end else begin
               if (state_q == DONE)
                  state_d = IDLE;
               if (!is_ext) begin
                  if (bus.we) begin
                     if (bus.addr == VIC_BORDER)
                        border_d = bus.cpu_do[3:0];
                     else if (bus.addr == VIC_BG)
                        bg_d = bus.cpu_do[3:0];
                  end else begin
                     cpu_di_d = int_data;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clkPhi0 or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cpu_di_q    <= 8'hFF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         count_q     <= 8'd0;
         bus_error_q <= 1'b0;
         border_q    <= 4'hE;
         bg_q        <= 4'h6;
      end else begin
         state_q     <= state_d;
         cpu_di_q    <= cpu_di_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         count_q     <= count_d;
         bus_error_q <= bus_error_d;
         border_q    <= border_d;
         bg_q        <= bg_d;
      end
   end

   assign bus.rdy       = !((state_q == IDLE && is_ext) || state_q == WAIT);
   assign bus.cpu_di    = cpu_di_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign border_color  = border_q;
   assign bg_color      = bg_q;
   assign bus_error     = bus_error_q;

endmodule
